pc_sequencer: RTL

Program-counter owner for the core. It consumes resolved control-flow decisions from execute, where the branch comparator supplies `branch_condition` and `branch_valid`, and produces the fetch address stream. It holds the PC and steps it on each accepted fetch. On a taken branch, JAL or JALR it redirects and flushes the front end for a fixed number of cycles. Illegal comparator results and (optionally) misaligned targets go to a trap state.

---
 rtl/pc_sequencer.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the program counter and produces the fetch address
// stream. Steps the PC on each accepted fetch, redirects on taken branches,
// JAL and JALR (flushing the front end for FLUSH_CYCLES cycles), and parks
// in a trap state on illegal comparator results.
//
// Optional feature macro: PC_MISALIGN_TRAP_EN
//   defined   - a redirect target with target[1:0] != 0 traps instead.
//   undefined - target[1:0] is forced to zero and the redirect proceeds.
module pc_sequencer #(
    parameter int                      ADDR_WIDTH   = 32,
    parameter int                      DATA_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0]   RESET_PC     = '0,
    parameter int                      FLUSH_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] fetch_pc,
    output logic                  fetch_valid,
    input  logic                  fetch_ready,
    input  logic                  resolve_valid,
    output logic                  resolve_ready,
    input  logic [1:0]            resolve_kind,
    input  logic [ADDR_WIDTH-1:0] resolve_pc,
    input  logic [DATA_WIDTH-1:0] resolve_imm,
    input  logic [DATA_WIDTH-1:0] resolve_rs1,
    input  logic                  branch_condition,
    input  logic                  branch_valid,
    output logic                  flush,
    output logic [ADDR_WIDTH-1:0] link_addr,
    output logic                  link_valid,
    output logic                  trap,
    output logic [ADDR_WIDTH-1:0] trap_addr,
    input  logic                  trap_clear
);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_TRAP  = 2'd3
    } state_t;

    localparam logic [1:0] KIND_SEQ  = 2'd0;
    localparam logic [1:0] KIND_BR   = 2'd1;
    localparam logic [1:0] KIND_JAL  = 2'd2;
    localparam logic [1:0] KIND_JALR = 2'd3;

    localparam int                CNT_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(4);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_pc;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_flush;
    logic                    r_link_valid;
    logic [ADDR_WIDTH-1:0]   r_link_addr;
    logic [ADDR_WIDTH-1:0]   r_trap_addr;

    logic [ADDR_WIDTH-1:0]   w_imm_ext;
    logic [ADDR_WIDTH-1:0]   w_rs1_ext;
    logic [ADDR_WIDTH-1:0]   w_raw_target;
    logic [ADDR_WIDTH-1:0]   w_target;
    logic                    w_accept;
    logic                    w_fetch_hs;
    logic                    w_wants_redirect;
    logic                    w_redirect;
    logic                    w_misaligned;
    logic                    w_illegal;
    logic                    w_link;

    // Decode the resolving op into a redirect target and trap conditions.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned, which would infer a latch.
        w_imm_ext        = ADDR_WIDTH'(signed'(resolve_imm));
        w_rs1_ext        = ADDR_WIDTH'(signed'(resolve_rs1));
        w_accept         = (r_state == S_RUN) && resolve_valid;
        w_fetch_hs       = (r_state == S_RUN) && fetch_ready;
        w_raw_target     = resolve_pc + w_imm_ext;
        w_wants_redirect = 1'b0;
        w_illegal        = 1'b0;
        w_link           = 1'b0;
        if (resolve_kind == KIND_JALR) begin
            w_raw_target = (w_rs1_ext + w_imm_ext) & ~ADDR_WIDTH'(1);
        end
        if (w_accept) begin
            case (resolve_kind)
                KIND_SEQ:  w_wants_redirect = 1'b0;
                KIND_BR: begin
                    w_illegal        = !branch_valid;
                    w_wants_redirect = branch_valid && branch_condition;
                end
                default: begin
                    w_wants_redirect = 1'b1;
                    w_link           = 1'b1;
                end
            endcase
        end
`ifdef PC_MISALIGN_TRAP_EN
        w_target     = w_raw_target;
        w_misaligned = w_wants_redirect && (w_raw_target[1:0] != 2'b00);
`else
        w_target     = w_raw_target & ~ADDR_WIDTH'(3);
        w_misaligned = 1'b0;
`endif
        w_redirect = w_wants_redirect && !w_misaligned;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_BOOT;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_BOOT:  w_state_nxt = S_RUN;
            S_RUN: begin
                if (w_redirect) begin
                    w_state_nxt = S_FLUSH;
                end else if (w_illegal || w_misaligned) begin
                    w_state_nxt = S_TRAP;
                end
            end
            S_FLUSH: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_TRAP: begin
                if (trap_clear) begin
                    w_state_nxt = S_RUN;
                end
            end
            default: w_state_nxt = S_BOOT;
        endcase
    end

    // Outputs that decode state only.
    always_comb begin
        fetch_valid   = (r_state == S_RUN);
        resolve_ready = (r_state == S_RUN);
        trap          = (r_state == S_TRAP);
    end

    // PC, flush counter, pulses, link and trap address registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc         <= RESET_PC;
            r_cnt        <= '0;
            r_flush      <= 1'b0;
            r_link_valid <= 1'b0;
            r_link_addr  <= '0;
            r_trap_addr  <= '0;
        end else begin
            r_flush      <= 1'b0;
            r_link_valid <= 1'b0;
            case (r_state)
                S_RUN: begin
                    // A redirect overrides the sequential +4 of a same-cycle fetch.
                    if (w_redirect) begin
                        r_pc    <= w_target;
                        r_flush <= 1'b1;
                        r_cnt   <= CNT_LOAD;
                        if (w_link) begin
                            r_link_valid <= 1'b1;
                            r_link_addr  <= resolve_pc + STEP;
                        end
                    end else if (w_fetch_hs) begin
                        r_pc <= r_pc + STEP;
                    end
                    if (w_illegal) begin
                        r_trap_addr <= resolve_pc;
                    end else if (w_misaligned) begin
                        r_trap_addr <= w_target;
                    end
                end
                S_FLUSH: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_TRAP: begin
                    if (trap_clear) begin
                        r_pc <= RESET_PC;
                    end
                end
                default: ;
            endcase
        end
    end

    assign fetch_pc   = r_pc;
    assign flush      = r_flush;
    assign link_valid = r_link_valid;
    assign link_addr  = r_link_addr;
    assign trap_addr  = r_trap_addr;

endmodule
